pipelined_reg_file: RTL and testbench
=====================================

// Module: pipelined_reg_file
// PURPOSE
//  Clocked, parametrised general-purpose register file for the MIPS datapath.
//  Two registered read ports and one write port, with write-to-read bypass and a
//  hardwired zero register. A per-register busy scoreboard lets decode stall on
//  results that are still pending (loads, multi-cycle ops).
//  Sits between decode (read/claim) and writeback (write/release).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: address 0 always reads 0 and ignores writes and claims; 0: address 0 is ordinary
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous, active-low reset
//  raddr1      in   ADDR_W   read port 1 address, sampled at the clk edge
//  raddr2      in   ADDR_W   read port 2 address, sampled at the clk edge
//  rdata1      out  DATA_W   read port 1 data, registered
//  rdata2      out  DATA_W   read port 2 data, registered
//  rbusy1      out  1        busy bit for raddr1, registered alongside rdata1
//  rbusy2      out  1        busy bit for raddr2, registered alongside rdata2
//  we          in   1        write enable
//  waddr       in   ADDR_W   write address
//  wdata       in   DATA_W   write data
//  claim_en    in   1        mark claim_addr busy (a producer has been issued)
//  claim_addr  in   ADDR_W   register to mark busy
//  flush       in   1        clear all busy bits (pipeline squash)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All entries = 0; all busy bits = 0; rdata1/2 = 0; rbusy1/2 = 0.
//   - Outputs and state hold these values while rst_n=0; normal operation resumes from the first rising edge after rst_n goes high.
//   - Reset asserted mid-write discards that write.
//  Write:
//   - On a rising edge with we=1, mem[waddr] <= wdata.
//   - A write also clears busy[waddr] (release).
//   - ZERO_REG=1 and waddr=0: write and release are ignored.
//  Read (latency 1):
//   - At edge N, rdataK <= value of raddrK, visible after edge N until edge N+1.
//   - Bypass: if we=1 and waddr=raddrK at edge N, rdataK <= wdata (new data, never stale).
//   - ZERO_REG=1 and raddrK=0: rdataK <= 0, rbusyK <= 0, regardless of any write.
//   - Both ports may read the same address; both then return identical data.
//  Scoreboard:
//   - busy_next computed per edge, in priority order (highest first):
//     1. flush=1: all bits cleared; claim and release are ignored.
//     2. claim_en=1: busy[claim_addr] set.
//     3. we=1: busy[waddr] cleared.
//   - Hence a claim and a write to the same address in one cycle leave the bit at 1 (new producer wins).
//   - Claims with ZERO_REG=1 and claim_addr=0 are ignored.
//   - rbusyK <= busy_next[raddrK], so the read port sees the same-edge claim, release or flush.
//   - The flush does not alter register contents or a same-cycle write's data.
//  Widths: all data is unsigned DATA_W bits; addresses index modulo DEPTH, and there is no out-of-range case.
//  No combinational path from any input to any output.
// TESTING
//  1. Reset: rst_n=0 mid-run -> rdata1/2=0 and rbusy1/2=0 immediately; after release, every address reads 0.
//  2. Write/read: we=1,waddr=20,wdata=50; next cycle raddr2=20 -> rdata2=50 one edge later; raddr1=0 -> rdata1=0.
//  3. Bypass: same edge we=1,waddr=7,wdata=0xDEADBEEF and raddr1=raddr2=7 -> after that edge rdata1=rdata2=0xDEADBEEF.
//  4. Zero reg: we=1,waddr=0,wdata=5, claim_en=1,claim_addr=0; then read 0 -> rdata=0, rbusy=0.
//  5. Scoreboard: claim 9 -> rbusy=1 on read of 9; same-cycle claim 9 and write 9 -> rbusy stays 1; write 9 alone -> rbusy=0 and data updated.
//  6. Flush: claim 3,4,5 over three cycles, then flush=1 with claim_en=1,claim_addr=6 -> reads of 3..6 all show rbusy=0.

Source files
------------

// File: rtl/pipelined_reg_file.sv
// General-purpose register file: two registered read ports, one write port with
// write-to-read bypass, optional hardwired zero register and a per-entry busy scoreboard.
module pipelined_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              flush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              writeOk;
  logic              claimOk;
  logic [DATA_W-1:0] rdataNext1;
  logic [DATA_W-1:0] rdataNext2;

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // New write data wins over the stored value so a reader never sees stale data.
  function automatic logic [DATA_W-1:0] readMux(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              wrEn,
    input logic [ADDR_W-1:0] wrAddr,
    input logic [DATA_W-1:0] wrData
  );
    if (isZeroReg(ra))
      return '0;
    else if (wrEn && (wrAddr == ra))
      return wrData;
    else
      return stored;
  endfunction

  assign writeOk = we && !isZeroReg(waddr);
  assign claimOk = claim_en && !isZeroReg(claim_addr);

  // Release first, then claim, so a same-cycle claim of the written entry keeps it busy.
  always_comb begin
    busyNext = busy;
    if (flush) begin
      busyNext = '0;
    end else begin
      if (writeOk) busyNext[waddr] = 1'b0;
      if (claimOk) busyNext[claim_addr] = 1'b1;
    end
  end

  assign rdataNext1 = readMux(raddr1, regs[raddr1], writeOk, waddr, wdata);
  assign rdataNext2 = readMux(raddr2, regs[raddr2], writeOk, waddr, wdata);

  // Storage and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (writeOk) regs[waddr] <= wdata;
      busy <= busyNext;
    end
  end

  // Registered read ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rbusy1 <= 1'b0;
      rbusy2 <= 1'b0;
    end else begin
      rdata1 <= rdataNext1;
      rdata2 <= rdataNext2;
      rbusy1 <= isZeroReg(raddr1) ? 1'b0 : busyNext[raddr1];
      rbusy2 <= isZeroReg(raddr2) ? 1'b0 : busyNext[raddr2];
    end
  end

endmodule

// File: tb/tb_pipelined_reg_file.sv
// Directed bench for pipelined_reg_file: reset, read/write, bypass, zero register,
// scoreboard priority and flush, with hand-computed expectations.
module tb_pipelined_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, waddr, claim_addr;
  logic [31:0] rdata1, rdata2, wdata;
  logic        rbusy1, rbusy2, we, claim_en, flush;

  int nChecks = 0;
  int nFails  = 0;

  pipelined_reg_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; raddr1 = '0; raddr2 = '0;
    idle();
    tick(); tick();
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_rdata2", rdata2, 32'h0);
    chk("reset_rbusy1", {31'b0, rbusy1}, 32'h0);
    #4 rst_n = 1'b1;
    tick();

    // write 20 then read it back on port 2, port 1 on the zero register
    we = 1'b1; waddr = 5'd20; wdata = 32'd50;
    tick();
    idle(); raddr1 = 5'd0; raddr2 = 5'd20;
    tick();
    chk("wr_rd_rdata2", rdata2, 32'd50);
    chk("wr_rd_rdata1_zero", rdata1, 32'd0);

    // same-edge bypass on both ports
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; raddr1 = 5'd7; raddr2 = 5'd7;
    tick();
    chk("bypass_rdata1", rdata1, 32'hDEADBEEF);
    chk("bypass_rdata2", rdata2, 32'hDEADBEEF);
    idle();
    tick();
    chk("stored_rdata1", rdata1, 32'hDEADBEEF);

    // zero register ignores write and claim
    we = 1'b1; waddr = 5'd0; wdata = 32'd5; claim_en = 1'b1; claim_addr = 5'd0;
    raddr1 = 5'd0; raddr2 = 5'd20;
    tick();
    chk("zero_bypass_rdata1", rdata1, 32'd0);
    chk("zero_bypass_rbusy1", {31'b0, rbusy1}, 32'd0);
    idle();
    tick();
    chk("zero_rdata1", rdata1, 32'd0);
    chk("zero_rbusy1", {31'b0, rbusy1}, 32'd0);
    chk("zero_other_rdata2", rdata2, 32'd50);

    // scoreboard: claim, claim+write, write alone
    claim_en = 1'b1; claim_addr = 5'd9; raddr1 = 5'd9; raddr2 = 5'd9;
    tick();
    chk("claim9_same_edge", {31'b0, rbusy1}, 32'd1);
    idle();
    tick();
    chk("claim9_held", {31'b0, rbusy2}, 32'd1);
    chk("claim9_data", rdata1, 32'd0);
    claim_en = 1'b1; claim_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h11;
    tick();
    chk("claim_write_busy", {31'b0, rbusy1}, 32'd1);
    chk("claim_write_data", rdata1, 32'h11);
    idle(); we = 1'b1; waddr = 5'd9; wdata = 32'h22;
    tick();
    chk("release_busy", {31'b0, rbusy1}, 32'd0);
    chk("release_data", rdata1, 32'h22);
    idle();
    tick();
    chk("release_busy_held", {31'b0, rbusy2}, 32'd0);
    chk("release_data_held", rdata2, 32'h22);

    // flush beats a same-cycle claim, keeps a same-cycle write's data
    claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    claim_addr = 5'd4;
    tick();
    claim_addr = 5'd5; raddr1 = 5'd3; raddr2 = 5'd4;
    tick();
    chk("pre_flush_busy3", {31'b0, rbusy1}, 32'd1);
    chk("pre_flush_busy4", {31'b0, rbusy2}, 32'd1);
    flush = 1'b1; claim_addr = 5'd6; we = 1'b1; waddr = 5'd10; wdata = 32'hABC;
    raddr1 = 5'd3; raddr2 = 5'd6;
    tick();
    chk("flush_busy3", {31'b0, rbusy1}, 32'd0);
    chk("flush_busy6", {31'b0, rbusy2}, 32'd0);
    idle(); raddr1 = 5'd4; raddr2 = 5'd5;
    tick();
    chk("flush_busy4", {31'b0, rbusy1}, 32'd0);
    chk("flush_busy5", {31'b0, rbusy2}, 32'd0);
    raddr1 = 5'd10; raddr2 = 5'd6;
    tick();
    chk("flush_write_data", rdata1, 32'hABC);
    chk("flush_claim6_ignored", {31'b0, rbusy2}, 32'd0);

    // mid-run async reset discards a pending write and busy state
    claim_en = 1'b1; claim_addr = 5'd13; raddr1 = 5'd7; raddr2 = 5'd13;
    tick();
    chk("pre_reset_busy13", {31'b0, rbusy2}, 32'd1);
    chk("pre_reset_rdata1", rdata1, 32'hDEADBEEF);
    idle(); we = 1'b1; waddr = 5'd12; wdata = 32'h77;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rdata1", rdata1, 32'd0);
    chk("async_rdata2", rdata2, 32'd0);
    chk("async_rbusy2", {31'b0, rbusy2}, 32'd0);
    tick();
    chk("reset_hold_rdata1", rdata1, 32'd0);
    idle();
    #4 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i + 16);
      tick();
      chk($sformatf("post_reset_rdata1_%0d", i), rdata1, 32'd0);
      chk($sformatf("post_reset_rdata2_%0d", i + 16), rdata2, 32'd0);
      chk($sformatf("post_reset_busy_%0d", i), {30'b0, rbusy1, rbusy2}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
